// File: rtl/stop_check_multi_if.sv
// stop_check_multi_if: sampler <-> stop checker bundle.
// master = RX sampler side, slave = checker.
interface stop_check_multi_if #(
  parameter int STOP_W    = 2,
  parameter int ERR_CNT_W = 8
) ();
  logic                 frame_start;
  logic                 data_bit_en;
  logic                 stp_chk_en;
  logic                 sampled_bit;
  logic [STOP_W-1:0]    stop_num;
  logic                 err_clr;
  logic                 stp_err;
  logic                 stp_done;
  logic                 brk_det;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output frame_start, data_bit_en, stp_chk_en,
    output sampled_bit, stop_num, err_clr,
    input  stp_err, stp_done, brk_det,
    input  err_sticky, err_cnt
  );

  modport slave (
    input  frame_start, data_bit_en, stp_chk_en,
    input  sampled_bit, stop_num, err_clr,
    output stp_err, stp_done, brk_det,
    output err_sticky, err_cnt
  );
endinterface

// File: rtl/stop_check_multi.sv
// stop_check_multi: multi stop-bit framing checker with
// break detect, sticky error and saturating error count.
module stop_check_multi #(
  parameter int STOP_W    = 2,
  parameter int ERR_CNT_W = 8
) (
  input logic               stop_check_clk,
  input logic               stop_check_rst,
  stop_check_multi_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  state_t               r_state;
  logic [STOP_W-1:0]    r_slot;
  logic [STOP_W-1:0]    r_nlat;
  logic                 r_bad;
  logic                 r_all_zero;
  logic                 r_stp_err;
  logic                 r_stp_done;
  logic                 r_brk_det;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [STOP_W-1:0]    w_nsel;
  logic                 w_first;
  logic                 w_last;
  logic                 w_bad;
  logic                 w_az;
  logic                 w_done;
  logic                 w_brk;
  logic                 w_inc;
  logic [ERR_CNT_W-1:0] w_cnt_base;

  // Next-state terms for the current stop bit.
  always_comb begin
    w_nsel = bus.stop_num;
    if (bus.stop_num == '0)
      w_nsel = STOP_W'(1);
    w_first = (r_state == S_IDLE);
    if (w_first) begin
      w_last = (w_nsel == STOP_W'(1));
      w_bad  = ~bus.sampled_bit;
    end else begin
      w_last = (r_slot == r_nlat - STOP_W'(1));
      w_bad  = r_bad | ~bus.sampled_bit;
    end
    w_az   = r_all_zero & ~bus.sampled_bit;
    w_done = bus.stp_chk_en & ~bus.frame_start
           & w_last;
    w_brk  = w_done & w_az;
    w_inc  = w_done & ~w_az & w_bad;
    w_cnt_base = r_err_cnt;
    if (bus.err_clr)
      w_cnt_base = '0;
  end

  // Frame FSM, error bookkeeping and registered outputs.
  always_ff @(posedge stop_check_clk or
              negedge stop_check_rst) begin
    if (!stop_check_rst) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_nlat       <= STOP_W'(1);
      r_bad        <= 1'b0;
      r_all_zero   <= 1'b1;
      r_stp_err    <= 1'b0;
      r_stp_done   <= 1'b0;
      r_brk_det    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_stp_done <= 1'b0;
      r_brk_det  <= 1'b0;
      if (bus.err_clr) begin
        r_err_cnt    <= '0;
        r_err_sticky <= 1'b0;
      end
      if (w_inc) begin
        r_err_sticky <= 1'b1;
        if (&w_cnt_base)
          r_err_cnt <= w_cnt_base;
        else
          r_err_cnt <= w_cnt_base + ERR_CNT_W'(1);
      end
      if (bus.frame_start) begin
        r_all_zero <= 1'b1;
        r_bad      <= 1'b0;
        r_slot     <= '0;
        r_state    <= S_IDLE;
      end else if (bus.stp_chk_en) begin
        r_bad <= w_bad;
        if (w_first)
          r_nlat <= w_nsel;
        if (w_done) begin
          r_stp_done <= 1'b1;
          r_stp_err  <= w_bad;
          r_brk_det  <= w_brk;
          r_state    <= S_IDLE;
          r_slot     <= '0;
          r_all_zero <= 1'b1;
        end else begin
          r_all_zero <= w_az;
          r_slot     <= r_slot + STOP_W'(1);
          r_state    <= S_COLLECT;
        end
      end else if (bus.data_bit_en &&
                   bus.sampled_bit) begin
        r_all_zero <= 1'b0;
      end
    end
  end

  assign bus.stp_err    = r_stp_err;
  assign bus.stp_done   = r_stp_done;
  assign bus.brk_det    = r_brk_det;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_stop_check_multi.sv
// tb_stop_check_multi: vector table plus scoreboard
// for the multi stop-bit checker (2-bit error count).
module tb_stop_check_multi;

  localparam int SW = 2;
  localparam int CW = 2;

  logic clk;
  logic rst_n;

  stop_check_multi_if #(
    .STOP_W(SW), .ERR_CNT_W(CW)
  ) sc ();

  stop_check_multi #(
    .STOP_W(SW), .ERR_CNT_W(CW)
  ) dut (
    .stop_check_clk(clk),
    .stop_check_rst(rst_n),
    .bus(sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] n;
    logic [8:0] data;
    logic [2:0] stops;
    logic       clr;
    logic       err;
    logic       brk;
    logic       sticky;
    logic [1:0] cnt;
  } vec_t;

  typedef struct {
    logic       err;
    logic       brk;
    logic       sticky;
    logic [1:0] cnt;
  } exp_t;

  vec_t vt[17];
  exp_t q[$];
  int   n_chk;
  int   n_fail;

  function automatic vec_t mk(
    input logic [1:0] n, input logic [7:0] d,
    input logic [2:0] s, input logic c,
    input logic e, input logic b,
    input logic st, input logic [1:0] cn);
    vec_t v;
    v.n = n; v.data = {d, 1'b0};
    v.stops = s; v.clr = c; v.err = e;
    v.brk = b; v.sticky = st; v.cnt = cn;
    return v;
  endfunction

  task automatic cmp(input string nm,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sc.stp_done) begin
      if (q.size() == 0) begin
        cmp("unexpected_stp_done", 1, 0);
      end else begin
        e = q.pop_front();
        cmp("stp_err", int'(sc.stp_err), int'(e.err));
        cmp("brk_det", int'(sc.brk_det), int'(e.brk));
        cmp("err_sticky", int'(sc.err_sticky),
            int'(e.sticky));
        cmp("err_cnt", int'(sc.err_cnt), int'(e.cnt));
      end
    end else if (sc.brk_det) begin
      cmp("brk_without_done", 1, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle_in();
    sc.frame_start = 1'b0;
    sc.data_bit_en = 1'b0;
    sc.stp_chk_en  = 1'b0;
    sc.sampled_bit = 1'b1;
    sc.err_clr     = 1'b0;
  endtask

  task automatic send_start_data(input logic [8:0] d);
    sc.frame_start = 1'b1;
    step();
    sc.frame_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sc.data_bit_en = 1'b1;
      sc.sampled_bit = d[i];
      step();
    end
    idle_in();
  endtask

  task automatic send_stop(input logic b);
    sc.stp_chk_en  = 1'b1;
    sc.sampled_bit = b;
    step();
    idle_in();
  endtask

  task automatic check_drained(input string nm);
    cmp(nm, q.size(), 0);
    q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int   ns;
    exp_t e;
    ns = (v.n == 2'd0) ? 1 : int'(v.n);
    sc.stop_num = v.n;
    send_start_data(v.data);
    for (int k = 0; k < ns; k++) begin
      if (k == ns - 1) begin
        e.err = v.err; e.brk = v.brk;
        e.sticky = v.sticky; e.cnt = v.cnt;
        q.push_back(e);
        sc.err_clr = v.clr;
      end
      sc.stp_chk_en  = 1'b1;
      sc.sampled_bit = v.stops[k];
      step();
      idle_in();
    end
    step();
    check_drained("missing_stp_done");
  endtask

  task automatic pulse_clr(input logic err_hold);
    sc.err_clr = 1'b1;
    step();
    idle_in();
    cmp("clr_err_cnt", int'(sc.err_cnt), 0);
    cmp("clr_err_sticky", int'(sc.err_sticky), 0);
    cmp("clr_stp_err_held", int'(sc.stp_err),
        int'(err_hold));
  endtask

  initial begin
    exp_t e;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_in();
    sc.stop_num = 2'd1;

    vt[0]  = mk(2'd1, 8'hA5, 3'b001, 0, 0, 0, 0, 2'd0);
    vt[1]  = mk(2'd2, 8'h3C, 3'b001, 0, 1, 0, 1, 2'd1);
    vt[2]  = mk(2'd2, 8'hFF, 3'b011, 0, 0, 0, 1, 2'd1);
    vt[3]  = mk(2'd2, 8'h00, 3'b000, 0, 1, 1, 1, 2'd1);
    vt[4]  = mk(2'd3, 8'h01, 3'b111, 0, 0, 0, 1, 2'd1);
    vt[5]  = mk(2'd3, 8'h00, 3'b110, 0, 1, 0, 1, 2'd2);
    vt[6]  = mk(2'd0, 8'h80, 3'b000, 0, 1, 0, 1, 2'd3);
    vt[7]  = mk(2'd1, 8'h55, 3'b000, 0, 1, 0, 1, 2'd3);
    vt[8]  = mk(2'd2, 8'h12, 3'b000, 0, 1, 0, 1, 2'd3);
    vt[9]  = mk(2'd0, 8'h00, 3'b000, 0, 1, 1, 1, 2'd3);
    vt[10] = mk(2'd3, 8'h00, 3'b101, 0, 1, 0, 1, 2'd3);
    vt[11] = mk(2'd1, 8'hF0, 3'b000, 0, 1, 0, 1, 2'd1);
    vt[12] = mk(2'd2, 8'h0F, 3'b010, 0, 1, 0, 1, 2'd2);
    vt[13] = mk(2'd3, 8'hAA, 3'b011, 0, 1, 0, 1, 2'd3);
    vt[14] = mk(2'd1, 8'h01, 3'b000, 0, 1, 0, 1, 2'd3);
    vt[15] = mk(2'd2, 8'h01, 3'b000, 0, 1, 0, 1, 2'd3);
    vt[16] = mk(2'd1, 8'h33, 3'b000, 1, 1, 0, 1, 2'd1);

    #12;
    cmp("rst_stp_err", int'(sc.stp_err), 0);
    cmp("rst_stp_done", int'(sc.stp_done), 0);
    cmp("rst_brk_det", int'(sc.brk_det), 0);
    cmp("rst_err_sticky", int'(sc.err_sticky), 0);
    cmp("rst_err_cnt", int'(sc.err_cnt), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i <= 10; i++) run_vec(vt[i]);
    pulse_clr(1'b1);
    for (int i = 11; i <= 16; i++) run_vec(vt[i]);
    pulse_clr(1'b1);

    sc.stop_num = 2'd3;
    send_start_data({8'hC3, 1'b0});
    send_stop(1'b0);
    sc.frame_start = 1'b1;
    sc.stp_chk_en  = 1'b1;
    sc.sampled_bit = 1'b0;
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("abort_no_done", int'(sc.stp_done), 0);
    end
    cmp("abort_err_held", int'(sc.stp_err), 1);

    send_start_data({8'h5A, 1'b0});
    send_stop(1'b1);
    sc.stop_num = 2'd1;
    send_stop(1'b1);
    cmp("latched_n_no_done", int'(sc.stp_done), 0);
    e.err = 1'b0; e.brk = 1'b0;
    e.sticky = 1'b0; e.cnt = 2'd0;
    q.push_back(e);
    send_stop(1'b1);
    step();
    check_drained("latched_n_done");

    run_vec(mk(2'd1, 8'h9E, 3'b000, 0, 1, 0, 1, 2'd1));
    sc.stop_num = 2'd2;
    send_start_data({8'h11, 1'b0});
    send_stop(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_stp_err", int'(sc.stp_err), 0);
    cmp("arst_stp_done", int'(sc.stp_done), 0);
    cmp("arst_brk_det", int'(sc.brk_det), 0);
    cmp("arst_err_sticky", int'(sc.err_sticky), 0);
    cmp("arst_err_cnt", int'(sc.err_cnt), 0);
    #4;
    rst_n = 1'b1;
    step();
    run_vec(mk(2'd1, 8'h7E, 3'b001, 0, 0, 0, 0, 2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
